// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, dbits data bits LSB-first, optional parity bit,
// then a stop period. Bit timing is counted in the oversample ticks shared with the receiver.
module uart_tx #(
    parameter int dbits      = 8,
    parameter int sample     = 16,
    parameter int stop_ticks = 16,
    parameter bit parity_en  = 1'b0,
    parameter bit parity_odd = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tx_start,
    input  logic [dbits-1:0] din,
    output logic             busy,
    output logic             tx_done,
    output logic             tx
);

    localparam int tick_max = (sample > stop_ticks) ? sample : stop_ticks;
    localparam int tw       = (tick_max > 1) ? $clog2(tick_max) : 1;
    localparam int bw       = $clog2(dbits + 1);

    localparam logic [tw-1:0] bit_end  = tw'(sample - 1);
    localparam logic [tw-1:0] stop_end = tw'(stop_ticks - 1);
    localparam logic [bw-1:0] last_bit = bw'(dbits - 1);

    typedef enum logic [2:0] {
        st_idle,
        st_start,
        st_data,
        st_parity,
        st_stop
    } state_t;

    state_t           state;
    logic [tw-1:0]    tick_cnt;
    logic [bw-1:0]    bit_cnt;
    logic [dbits-1:0] shreg;
    logic [dbits-1:0] shreg_next;
    logic             par;
    logic             bit_done;
    logic             stop_done;

    assign shreg_next = shreg >> 1;
    assign bit_done   = tick && (tick_cnt == bit_end);
    assign stop_done  = tick && (tick_cnt == stop_end);

    // NOTE: every register here uses <= so all updates see pre-edge values; blocking
    // assignments would let the shift, parity and tx updates race each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                st_idle: begin
                    tx <= 1'b1;
                    // A tick coinciding with acceptance is deliberately not counted.
                    if (tx_start) begin
                        shreg    <= din;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par      <= 1'b0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= st_start;
                    end
                end

                st_start: begin
                    if (bit_done) begin
                        tick_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= st_data;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                st_data: begin
                    if (bit_done) begin
                        tick_cnt <= '0;
                        shreg    <= shreg_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        par      <= par ^ shreg[0];
                        if (bit_cnt == last_bit) begin
                            if (parity_en) begin
                                tx    <= par ^ shreg[0] ^ parity_odd;
                                state <= st_parity;
                            end else begin
                                tx    <= 1'b1;
                                state <= st_stop;
                            end
                        end else begin
                            tx <= shreg_next[0];
                        end
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                st_parity: begin
                    if (bit_done) begin
                        tick_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= st_stop;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                st_stop: begin
                    tx <= 1'b1;
                    // busy drops with tx_done so a request in that cycle starts the next frame.
                    if (stop_done) begin
                        tick_cnt <= '0;
                        busy     <= 1'b0;
                        tx_done  <= 1'b1;
                        state    <= st_idle;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    tick_cnt <= '0;
                    busy     <= 1'b0;
                    tx       <= 1'b1;
                    state    <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations share clk/tick; each frame is
// compared tick-by-tick against an arithmetic frame model, plus a behavioural loopback receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] tx_start;
    logic [7:0] din [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int tick_div = 4;
    int tick_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity_en(1'b0), .parity_odd(1'b0)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start[0]), .din(din[0]),
        .busy(busy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity_en(1'b1), .parity_odd(1'b0)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start[1]), .din(din[1]),
        .busy(busy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity_en(1'b1), .parity_odd(1'b1)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start[2]), .din(din[2]),
        .busy(busy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));
    uart_tx #(.dbits(8), .sample(16), .stop_ticks(32), .parity_en(1'b0), .parity_odd(1'b0)) u3 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start[3]), .din(din[3]),
        .busy(busy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3]));

    // Baud tick: one-cycle pulse every tick_div clocks, driven away from the active edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_div - 1) begin
                tick     = 1'b1;
                tick_cnt = 0;
            end else begin
                tick     = 1'b0;
                tick_cnt = tick_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_ticks(input int pen, input int stop_t);
        return (1 + 8 + pen) * 16 + stop_t;
    endfunction

    // Line level n ticks after the frame was accepted: bit index is n/16.
    function automatic logic exp_tx(input logic [7:0] data, input int pen, input int podd, input int n);
        int b;
        b = n / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (pen != 0 && b == 9) return (^data) ^ podd[0];
        return 1'b1;
    endfunction

    task automatic start_frame(input int idx, input logic [7:0] data);
        @(negedge clk);
        tx_start[idx] = 1'b1;
        din[idx]      = data;
    endtask

    // Follows a frame from its acceptance edge until `limit` ticks have been counted.
    task automatic check_frame(input int idx, input logic [7:0] data, input int pen, input int podd,
                               input int stop_t, input bit release_start, input int limit);
        int total;
        int n;
        int cyc;
        logic t;
        total = frame_ticks(pen, stop_t);
        @(posedge clk);
        #1;
        if (release_start) tx_start[idx] = 1'b0;
        n   = 0;
        cyc = 0;
        check("accept_tx", tx_w[idx], 0);
        check("accept_busy", busy_w[idx], 1);
        check("accept_done", done_w[idx], 0);
        while (n < limit && cyc < limit * 8 + 100) begin
            @(posedge clk);
            t = tick;
            #1;
            cyc = cyc + 1;
            if (t) n = n + 1;
            check("tx", tx_w[idx], exp_tx(data, pen, podd, n));
            check("busy", busy_w[idx], (n < total) ? 1 : 0);
            check("done", done_w[idx], (n == total) ? 1 : 0);
        end
        if (n < limit) check("timeout_ticks", n, limit);
    endtask

    task automatic wait_ticks(input int k);
        int c;
        c = 0;
        while (c < k) begin
            @(posedge clk);
            if (tick) c = c + 1;
            #1;
        end
    endtask

    // Behavioural receiver on u3's line: detect the falling edge, then sample at mid-bit.
    initial begin : rx_model
        logic [7:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (tx_w[3] == 1'b0) begin
                wait_ticks(8);
                check("rx_start_bit", tx_w[3], 0);
                for (int i = 0; i < 8; i++) begin
                    wait_ticks(16);
                    w[i] = tx_w[3];
                end
                wait_ticks(16);
                check("rx_stop_bit", tx_w[3], 1);
                rx_q.push_back(w);
            end
        end
    end

    initial begin
        logic [7:0] w;
        rst      = 1'b1;
        tx_start = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_tx", tx_w[0], 1);
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_tx_all", tx_w, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame, tick every 4 clocks.
        start_frame(0, 8'hA5);
        check_frame(0, 8'hA5, 0, 0, 16, 1'b1, frame_ticks(0, 16));
        @(posedge clk);
        #1;
        check("a5_done_once", done_w[0], 0);
        check("a5_idle_tx", tx_w[0], 1);

        // Parity variants.
        start_frame(1, 8'h07);
        check_frame(1, 8'h07, 1, 0, 16, 1'b1, frame_ticks(1, 16));
        start_frame(2, 8'h07);
        check_frame(2, 8'h07, 1, 1, 16, 1'b1, frame_ticks(1, 16));

        // tx_start held: back-to-back frames, din changed while the first is in flight.
        start_frame(0, 8'h55);
        fork
            check_frame(0, 8'h55, 0, 0, 16, 1'b0, frame_ticks(0, 16));
            begin
                @(posedge clk);
                #2;
                din[0] = 8'hAA;
            end
        join
        check_frame(0, 8'hAA, 0, 0, 16, 1'b1, frame_ticks(0, 16));
        @(posedge clk);
        #1;
        check("b2b_no_third", busy_w[0], 0);
        check("b2b_done_clear", done_w[0], 0);

        // A mid-frame request with different data must be ignored.
        start_frame(0, 8'h96);
        fork
            check_frame(0, 8'h96, 0, 0, 16, 1'b1, frame_ticks(0, 16));
            begin
                repeat (200) @(negedge clk);
                tx_start[0] = 1'b1;
                din[0]      = 8'h69;
                @(negedge clk);
                tx_start[0] = 1'b0;
            end
        join

        // Reset in data bit 3, then a clean frame.
        start_frame(0, 8'hF0);
        check_frame(0, 8'hF0, 0, 0, 16, 1'b1, 4 * 16 + 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", tx_w[0], 1);
        check("midrst_busy", busy_w[0], 0);
        check("midrst_done", done_w[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        start_frame(0, 8'h3C);
        check_frame(0, 8'h3C, 0, 0, 16, 1'b1, frame_ticks(0, 16));

        // Loopback: 200 random words, two stop bits.
        for (int i = 0; i < 200; i++) begin
            tick_div = (i < 40) ? 2 : 1;
            w = 8'($urandom);
            sent_q.push_back(w);
            start_frame(3, w);
            check_frame(3, w, 0, 0, 32, 1'b1, frame_ticks(0, 32));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("rx_count", rx_q.size(), 200);
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            check("rx_word", rx_q[i], sent_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter: accepts a parallel word, shifts it out LSB-first on `tx` as start bit, data bits, optional parity bit, then stop bit(s).
- Bit timing comes from the shared oversampling baud `tick`, the same tick that drives the UART receiver, so one tick generator serves both directions.
- Sits between the host-side register/FIFO logic and the serial pin; pairs with the receiver for loopback testing.

Parameters:
- dbits, 8, number of data bits per frame (1..16)
- sample, 16, ticks per bit period (start, data, parity bits)
- stop_ticks, 16, ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2 at sample=16)
- parity_en, 0, 1 = insert a parity bit after the data bits
- parity_odd, 0, 0 = even parity, 1 = odd parity (ignored when parity_en=0)

Ports:
- clk  input  1  system clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  baud oversample enable, one-cycle pulse, `sample` pulses per bit
- tx_start  input  1  request to send `din`; sampled every cycle
- din  input  dbits  data word; captured on an accepted tx_start
- busy  output  1  high while a frame is in progress (state != idle)
- tx_done  output  1  one-cycle pulse when the stop period completes
- tx  output  1  serial line, registered, idle high

Behaviour:
- Reset values (rst sampled high at a clk edge): tx=1, busy=0, tx_done=0, state=idle, tick counter=0, bit counter=0, shift register=0. Reset takes priority over every other event, including mid-frame; tx returns high on that same edge and the partial frame is abandoned.
- States: idle, start, data, parity, stop. Encode in 3 bits.
- idle:
  - tx=1.
  - If tx_start=1, latch din into the shift register, clear both counters, go to start.
  - tx_start while not idle is ignored; din is not re-latched.
- Tick counter: counts ticks within the current bit and clears on every state change.
  - A bit ends on the clk edge where tick=1 and count = sample-1 (stop: stop_ticks-1).
  - Cycles without tick hold all state.
- start: tx=0. On bit end go to data.
- data:
  - tx = shift register bit 0.
  - On each bit end: shift right, increment the bit counter, and accumulate parity (XOR of data bits).
  - After dbits bits, go to parity if parity_en=1, else stop.
- parity: tx = XOR(data) XOR parity_odd. On bit end go to stop.
- stop: tx=1. On stop end go to idle and pulse tx_done for exactly one cycle, on the first idle cycle.
- tx is registered: the line change lags the state change by at most one clk.
  - Start bit: tx falls on the edge after tx_start acceptance (the edge entering start), and is low for sample ticks from then.
  - Since the tick phase is arbitrary, the first bit may include up to one tick period of extra low time before the first counted tick. This is acceptable.
- busy = (state != idle). It is low in the tx_done cycle, so tx_start in that same cycle is accepted (back-to-back frames, no idle bit inserted beyond the stop period).
- Frame length = (1 + dbits + parity_en)·sample + stop_ticks ticks.
- Counter widths: sized to hold max(sample, stop_ticks)-1 and dbits. No overflow or wrap beyond these bounds.
- tick and tx_start arriving in the same cycle: tx_start is accepted, and that tick is not counted toward the start bit.

Test Plan:
- Reset, then tick every 4 clk, sample=16, tx_start with din=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 ticks (64 clk); tx_done pulses once after 160 ticks; busy high for the whole frame.
- parity_en=1, parity_odd=0, din=0x07 -> parity bit = 1, frame of 11 bits; with parity_odd=1 -> parity bit = 0.
- tx_start held high continuously with din 0x55 then 0xAA -> two frames back-to-back; the second start bit follows the first stop period with no extra idle; exactly two tx_done pulses.
- tx_start pulsed mid-frame with a different din -> ignored; transmitted word unchanged.
- Assert rst during data bit 3 -> tx=1, busy=0, tx_done=0 on the next edge; a subsequent tx_start with 0x3C sends a clean frame.
- Loopback into the UART receiver (same tick), random 200 words, stop_ticks=32 -> every received word equals the transmitted word, and the receiver's done count is 200.
